expr_string_gen: RTL and testbench

- Transmit-side counterpart of the team's expression-string recognizer.
- Serializes a latched list of BCD operands and operators into an ASCII character stream of the form digit (op digit)*, one character per accepted handshake. Operators are '+' or '*'.
- Every stream it produces is accepted by the recognizer. It sits upstream of the recognizer as a stimulus and loopback source.

---
 rtl/expr_pkg.sv | 18 +
 rtl/bcd_to_ascii.sv | 11 +
 rtl/expr_string_gen.sv | 181 ++++++++++++++++++
 tb/tb_expr_string_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared types and character constants for the expression-string generator and recognizer.
package expr_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SEND_DIG = 2'b01,
    SEND_OP  = 2'b10,
    SPARE    = 2'b11
  } state_e;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;

  localparam logic OP_PLUS = 1'b0;
  localparam logic OP_STAR = 1'b1;

endpackage

// File: rtl/bcd_to_ascii.sv
// Maps one BCD digit to its ASCII character; callers guarantee the digit is 0..9.
module bcd_to_ascii
  import expr_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] ascii
);

  assign ascii = CH_ZERO + {4'h0, bcd};

endmodule

// File: rtl/expr_string_gen.sv
// Serializes a latched digit/operator list into an ASCII "d(op d)*" stream.
// Define EXPR_GEN_EVAL_EN to add a left-to-right evaluator (result, result_valid).
module expr_string_gen
  import expr_pkg::*;
#(
  parameter  int MAX_TERMS = 8,
  localparam int NW        = $clog2(MAX_TERMS + 1)
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [NW-1:0]          num_terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  output logic                   busy,
  output logic [7:0]             out_char,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
`ifdef EXPR_GEN_EVAL_EN
  output logic [15:0]            result,
  output logic                   result_valid,
`endif
  output logic                   err
);

  localparam int IW = $clog2(MAX_TERMS);

  // Handshake: a character moves on a rising edge where out_valid && out_ready;
  // while out_valid is high and out_ready low, out_char/out_last stay put.

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NW-1:0]          num_terms_q, num_terms_d;
  logic [4*MAX_TERMS-1:0] digits_q, digits_d;
  logic [MAX_TERMS-1:0]   ops_q, ops_d;
  logic                   err_q, err_d;

  logic       start_ok;
  logic       xfer;
  logic       is_last;
  logic [3:0] cur_digit;
  logic       cur_op;
  logic [7:0] digit_char;

  always_comb begin
    start_ok = (num_terms != '0) && (num_terms <= NW'(MAX_TERMS));
    for (int i = 0; i < MAX_TERMS; i++) begin
      if ((NW'(i) < num_terms) && (digits[4*i +: 4] > 4'd9)) start_ok = 1'b0;
    end
  end

  always_comb begin
    cur_digit = 4'h0;
    cur_op    = OP_PLUS;
    for (int i = 0; i < MAX_TERMS; i++) begin
      if (IW'(i) == idx_q) begin
        cur_digit = digits_q[4*i +: 4];
        cur_op    = ops_q[i];
      end
    end
  end

  assign is_last = (NW'(idx_q) == (num_terms_q - NW'(1)));

  bcd_to_ascii u_bcd_to_ascii (
    .bcd   (cur_digit),
    .ascii (digit_char)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start && start_ok) state_d = SEND_DIG;
      SEND_DIG: if (xfer) state_d = is_last ? IDLE : SEND_OP;
      SEND_OP:  if (xfer) state_d = SEND_DIG;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    out_char  = 8'h00;
    out_last  = 1'b0;
    case (state_q)
      SEND_DIG: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_char  = digit_char;
        out_last  = is_last;
      end
      SEND_OP: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_char  = (cur_op == OP_STAR) ? CH_STAR : CH_PLUS;
      end
      default: ;
    endcase
  end

  assign xfer = out_valid && out_ready;
  assign err  = err_q;

  always_comb begin
    idx_d       = idx_q;
    num_terms_d = num_terms_q;
    digits_d    = digits_q;
    ops_d       = ops_q;
    err_d       = 1'b0;
    if (state_q == IDLE && start) begin
      if (start_ok) begin
        idx_d       = '0;
        num_terms_d = num_terms;
        digits_d    = digits;
        ops_d       = {1'b0, ops};
      end else begin
        err_d = 1'b1;
      end
    end
    if (state_q == SEND_OP && xfer) idx_d = idx_q + IW'(1);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      idx_q       <= '0;
      num_terms_q <= '0;
      digits_q    <= '0;
      ops_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      num_terms_q <= num_terms_d;
      digits_q    <= digits_d;
      ops_q       <= ops_d;
      err_q       <= err_d;
    end
  end

`ifdef EXPR_GEN_EVAL_EN
  logic [15:0] acc_q, acc_d;
  logic        last_op_q, last_op_d;
  logic        result_valid_q, result_valid_d;

  // The operator preceding a digit is remembered when it is sent, so the
  // digit transfer can fold it into the accumulator without precedence.
  always_comb begin
    acc_d          = acc_q;
    last_op_d      = last_op_q;
    result_valid_d = 1'b0;
    if (state_q == SEND_OP && xfer) last_op_d = cur_op;
    if (state_q == SEND_DIG && xfer) begin
      if (idx_q == '0)              acc_d = {12'h000, cur_digit};
      else if (last_op_q == OP_STAR) acc_d = acc_q * {12'h000, cur_digit};
      else                           acc_d = acc_q + {12'h000, cur_digit};
      result_valid_d = is_last;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      acc_q          <= 16'h0000;
      last_op_q      <= OP_PLUS;
      result_valid_q <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      last_op_q      <= last_op_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result       = acc_q;
  assign result_valid = result_valid_q;
`endif

endmodule

// File: tb/tb_expr_string_gen.sv
// Scoreboard bench for expr_string_gen: drivers queue the expected characters,
// a negedge monitor pops and compares on every transfer.
module tb_expr_string_gen;

  localparam int MT = 8;
  localparam int NW = 4;

  logic            clk = 1'b0;
  logic            clr;
  logic            start;
  logic [NW-1:0]   num_terms;
  logic [4*MT-1:0] digits;
  logic [MT-2:0]   ops;
  logic            busy;
  logic [7:0]      out_char;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            err;
`ifdef EXPR_GEN_EVAL_EN
  logic [15:0]     result;
  logic            result_valid;
`endif

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  expr_string_gen #(.MAX_TERMS(MT)) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .num_terms    (num_terms),
    .digits       (digits),
    .ops          (ops),
    .busy         (busy),
    .out_char     (out_char),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
`ifdef EXPR_GEN_EVAL_EN
    .result       (result),
    .result_valid (result_valid),
`endif
    .err          (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer will happen at the next posedge when valid&&ready now.
  logic       stalled = 1'b0;
  logic [7:0] st_char;
  logic       st_last;
  logic [8:0] mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (clr) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid", out_valid, 1);
          check("stall_char", out_char, st_char);
          check("stall_last", out_last, st_last);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_char: got %0h expected none", out_char);
          end else begin
            mon_e = exp_q.pop_front();
            check("char", out_char, mon_e[7:0]);
            check("last", out_last, mon_e[8]);
          end
        end
        stalled = out_valid && !out_ready;
        st_char = out_char;
        st_last = out_last;
      end
    end
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back({(i == s.len() - 1), s[i]});
  endtask

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    return (c % 3) == 0;
  endfunction

  // Starts a stream and follows it until busy drops; inject_at >= 1 raises a
  // valid start on that cycle, which must be ignored.
  task automatic run_stream(input string s, input int n, input logic [31:0] d,
                            input logic [6:0] o, input int stall_mode,
                            input int inject_at, input logic [15:0] exp_res);
    int  cycles;
    bit  done;
    push_str(s);
    num_terms = NW'(n);
    digits    = d;
    ops       = o;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({s, "_busy_on"}, busy, 1);
    check({s, "_first_valid"}, out_valid, 1);
    digits    = 32'h2222_2222;
    ops       = 7'h00;
    num_terms = NW'(3);
    out_ready = ready_for(stall_mode, 0);
    cycles = 0;
    done   = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      cycles++;
      start = 1'b0;
      if (!busy) begin
        done = 1'b1;
      end else if (cycles > 200) begin
        total++;
        bad++;
        $display("FAIL %s_timeout: got busy after %0d cycles expected idle", s, cycles);
        done = 1'b1;
      end else begin
        check({s, "_no_err"}, err, 0);
        out_ready = ready_for(stall_mode, cycles);
        if (cycles == inject_at) begin
          num_terms = NW'(2);
          digits    = 32'h1111_1111;
          start     = 1'b1;
        end
      end
    end
    if (stall_mode == 0) check({s, "_cycles"}, cycles, 2 * n - 1);
    check({s, "_queue_empty"}, exp_q.size(), 0);
`ifdef EXPR_GEN_EVAL_EN
    check({s, "_result_valid"}, result_valid, 1);
    check({s, "_result"}, result, exp_res);
`else
    check({s, "_exp_res_range"}, (exp_res <= 16'hFFFF), 1);
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({s, "_idle_busy"}, busy, 0);
    check({s, "_idle_valid"}, out_valid, 0);
`ifdef EXPR_GEN_EVAL_EN
    check({s, "_result_pulse"}, result_valid, 0);
`endif
  endtask

  task automatic reject(input string tag, input int n, input logic [31:0] d);
    num_terms = NW'(n);
    digits    = d;
    ops       = 7'h00;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_err"}, err, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_err_pulse"}, err, 0);
    check({tag, "_busy2"}, busy, 0);
    check({tag, "_valid2"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr       = 1'b1;
    start     = 1'b0;
    num_terms = '0;
    digits    = '0;
    ops       = '0;
    out_ready = 1'b1;
    #2;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_err", err, 0);
    check("rst_char", out_char, 8'h00);
`ifdef EXPR_GEN_EVAL_EN
    check("rst_result", result, 0);
    check("rst_result_valid", result_valid, 0);
`endif
    @(posedge clk); @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;

    run_stream("1+7*4", 3, 32'h0000_0471, 7'b000_0010, 0, -1, 16'd32);
    run_stream("9", 1, 32'h0000_0009, 7'h00, 0, -1, 16'd9);
    run_stream("1+7*4", 3, 32'h0000_0471, 7'b000_0010, 1, -1, 16'd32);
    run_stream("5*0", 2, 32'hFFFF_FF05, 7'b000_0001, 0, -1, 16'd0);

    reject("n0", 0, 32'h0000_0123);
    reject("n9", 9, 32'h0000_0123);
    reject("digA", 3, 32'h0000_01A3);

    // Abort a 4-term stream after its second character.
    push_str("2+5*3+8");
    num_terms = NW'(4);
    digits    = 32'h0000_8352;
    ops       = 7'b000_0010;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("clr_popped_two", exp_q.size(), 5);
    clr = 1'b1;
    #1;
    check("clr_valid", out_valid, 0);
    check("clr_busy", busy, 0);
    check("clr_last", out_last, 0);
    check("clr_char", out_char, 8'h00);
`ifdef EXPR_GEN_EVAL_EN
    check("clr_result", result, 0);
`endif
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    clr = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_clr_valid", out_valid, 0);
      check("post_clr_busy", busy, 0);
    end
    run_stream("2+5*3+8", 4, 32'h0000_8352, 7'b000_0010, 0, -1, 16'd29);

    run_stream("9*9*9*9*9*9*9*9", 8, 32'h9999_9999, 7'h7F, 0, 2, 16'd55105);
    run_stream("0+5", 2, 32'h0000_0050, 7'b000_0000, 0, 2, 16'd5);
    run_stream("3*2", 2, 32'h0000_0023, 7'b000_0001, 1, 3, 16'd6);

    repeat (2) @(posedge clk);
    #1;
    check("end_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
